// File: rtl/carry_look_sub_serial.sv
// carry_look_sub_serial
//   Digit-serial subtractor. It computes diff = a - b - bin, one 4-bit slice
//   per clock, least significant slice first. Each slice is a 4-bit
//   carry-look-ahead adder that evaluates a + ~b + carry. The carry into
//   slice 0 is ~bin, and the borrow out is the inverted final carry.
//   A valid/ready handshake wraps the operation on the request side and on
//   the result side.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous reset, active-low
//   in_valid   in   operand request valid
//   in_ready   out  high exactly when idle (request can be accepted)
//   a          in   [WIDTH-1:0] minuend
//   b          in   [WIDTH-1:0] subtrahend
//   bin        in   borrow-in
//   out_valid  out  high exactly when a result is being presented
//   out_ready  in   consumer accepts the result
//   diff       out  [WIDTH-1:0] a - b - bin modulo 2^WIDTH
//   bout       out  unsigned borrow-out (a < b + bin)
//   ovf        out  two's-complement overflow of the subtraction
//   zero       out  diff == 0
module carry_look_sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, acc_d;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0] a_s, b_s, g, p, sum;
  logic [4:0] c;
  logic       last;

  assign last      = (cnt == CW'(NSLICE - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Slice datapath. The slice index picks the operand nibbles. The look-ahead
  // carries are written out as flat sum-of-products so that no carry waits
  // for the carry below it.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment.
    // Without the default, a path that skips the assignment would infer a latch.
    a_s   = '0;
    b_s   = '0;
    acc_d = acc;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_s = a_q[4*k +: 4];
        b_s = b_q[4*k +: 4];
      end
    end

    g = a_s & ~b_s;
    p = a_s ^ ~b_s;

    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);

    sum = p ^ c[3:0];

    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) acc_d[4*k +: 4] = sum;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, and the order of the statements does
  // not change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            carry <= ~bin;
          end
        end
        CALC: begin
          acc   <= acc_d;
          carry <= c[4];
          if (last) begin
            cnt  <= '0;
            diff <= acc_d;
            bout <= ~c[4];
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (acc_d[WIDTH-1] != a_q[WIDTH-1]);
            zero <= (acc_d == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_look_sub_serial.sv
// Testbench for carry_look_sub_serial at WIDTH=16. It applies directed
// vectors with hand-computed results, then a backpressure scenario and an
// abort by reset, then random back-to-back requests checked against a
// behavioural subtraction.
module tb_carry_look_sub_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout, ovf, zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  carry_look_sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge while idle. Issues one request and waits for the
  // result within a bounded number of cycles. It then checks the result and
  // the latency, completes the result handshake, and returns idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input string tag);
    logic [W:0]   full;
    logic [W-1:0] e_diff;
    logic         e_bout, e_ovf;
    int           lat;
    full   = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    e_diff = full[W-1:0];
    e_bout = full[W];
    e_ovf  = (ta[W-1] != tb_v[W-1]) && (e_diff[W-1] != ta[W-1]);

    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(posedge clk); #1;
    // Scramble the inputs after the accept. The result must not follow them.
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat),    32'd4);
    check({tag, " diff"},    32'(diff),   32'(e_diff));
    check({tag, " bout"},    32'(bout),   32'(e_bout));
    check({tag, " ovf"},     32'(ovf),    32'(e_ovf));
    check({tag, " zero"},    32'(zero),   32'(e_diff == '0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle"},    32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_diff;
    logic         held_bout, held_ovf, held_zero;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst diff",      32'(diff),      32'd0);
    check("rst flags",     32'({bout, ovf, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_op(16'h0000, 16'h0000, 1'b0, "v0");
    run_op(16'h0000, 16'h0001, 1'b0, "v1");
    run_op(16'h8000, 16'h0001, 1'b0, "v2");
    run_op(16'h1234, 16'h0234, 1'b1, "v3");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, "v4");  // signed overflow, borrow
    run_op(16'hFFFF, 16'hFFFF, 1'b1, "v5");  // borrow generated only by bin

    // Backpressure: hold the result while new requests are offered
    in_valid = 1'b1; a = 16'h00F0; b = 16'h000F; bin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 32'(lat),  32'd4);
    check("bp diff",    32'(diff), 32'h00E1);
    held_diff = diff; held_bout = bout; held_ovf = ovf; held_zero = zero;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      check("bp hold diff",  32'(diff), 32'(held_diff));
      check("bp hold flags", 32'({bout, ovf, zero}),
            32'({held_bout, held_ovf, held_zero}));
      check("bp in_ready",   32'(in_ready),  32'd0);
      check("bp out_valid",  32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release in_ready",  32'(in_ready),  32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);

    // Abort by reset in the second CALC cycle
    in_valid = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0;
    @(posedge clk); #1;          // accepted, first CALC cycle
    in_valid = 1'b0;
    @(posedge clk); #1;          // second CALC cycle
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready",  32'(in_ready),  32'd1);
    check("abort diff",      32'(diff),      32'd0);
    check("abort flags",     32'({bout, ovf, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort no result", 32'(out_valid), 32'd0);
    run_op(16'h0005, 16'h0003, 1'b0, "post_rst");

    // Random back-to-back requests
    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
